// File: rtl/ltm_pkg.sv
// Shared constants and types for the LTM frame-buffer scan path.
package ltm_pkg;

  localparam int unsigned LTM_WIDTH    = 800;
  localparam int unsigned LTM_HEIGHT   = 480;
  localparam int unsigned LTM_VBL_CYC  = 1000;
  localparam int unsigned LTM_ADDR_W   = 19;
  localparam int unsigned LTM_DATA_W   = 16;
  localparam int unsigned LTM_WQ_DEPTH = 4;

  typedef enum logic [1:0] {
    StSeek,
    StActive,
    StHblank,
    StVblank
  } scan_state_e;

  typedef logic [LTM_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/ltm_wr_queue.sv
// Small FIFO holding drawing-engine writes until the panel scan leaves the memory idle.
module ltm_wr_queue
  import ltm_pkg::*;
#(
  parameter int unsigned Width = LTM_ADDR_W + LTM_DATA_W,
  parameter int unsigned Depth = LTM_WQ_DEPTH  // power of 2, at least 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ltm_fb_scan_arbiter.sv
// Shares the single-port frame buffer: panel scan-out reads always win, queued
// drawing-engine writes drain only while DEN is low.
module ltm_fb_scan_arbiter
  import ltm_pkg::*;
#(
  parameter int unsigned WIDTH    = LTM_WIDTH,
  parameter int unsigned HEIGHT   = LTM_HEIGHT,
  parameter int unsigned ADDR_W   = LTM_ADDR_W,
  parameter int unsigned DATA_W   = LTM_DATA_W,
  parameter int unsigned WQ_DEPTH = LTM_WQ_DEPTH,
  parameter int unsigned VBL_CYC  = LTM_VBL_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              den_lcd,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              frame_start,
  output logic              scan_locked
);

  localparam int unsigned CntW = $clog2(VBL_CYC + 1);
  localparam int unsigned QW   = ADDR_W + DATA_W;

  scan_state_e       state_q;
  logic [10:0]       x_q, y_q;
  logic [ADDR_W-1:0] line_base_q;
  logic [CntW-1:0]   lo_cnt_q;
  logic              den_q;
  logic              frame_start_q, scan_locked_q, pix_valid_q;
  logic [DATA_W-1:0] pix_data_q;

  logic              den_fall, vbl_hit;
  logic              q_full, q_empty, q_push, q_pop;
  logic [QW-1:0]     q_head;

  assign den_fall = den_q & ~den_lcd;
  assign vbl_hit  = ~den_lcd & (lo_cnt_q == CntW'(VBL_CYC - 1));

  assign wr_ready    = ~q_full;
  assign q_push      = wr_valid & ~q_full;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign scan_locked = scan_locked_q;

  ltm_wr_queue #(
    .Width(QW),
    .Depth(WQ_DEPTH)
  ) u_wr_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .push_data({wr_addr, wr_data}),
    .pop      (q_pop),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

  // Memory mux follows DEN directly; reset is folded in so every strobe drops at once.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    q_pop     = 1'b0;
    if (reset) begin
      if (den_lcd) begin
        mem_rd   = 1'b1;
        mem_addr = line_base_q + ADDR_W'(x_q);
      end else if (!q_empty) begin
        mem_wr    = 1'b1;
        q_pop     = 1'b1;
        mem_addr  = q_head[QW-1 -: ADDR_W];
        mem_wdata = q_head[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StSeek;
      x_q           <= '0;
      y_q           <= '0;
      line_base_q   <= '0;
      lo_cnt_q      <= '0;
      den_q         <= 1'b0;
      frame_start_q <= 1'b0;
      scan_locked_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
    end else begin
      den_q <= den_lcd;

      if (!den_lcd)                     x_q <= '0;
      else if (x_q == 11'(WIDTH - 1))   x_q <= '0;
      else                              x_q <= x_q + 11'd1;

      if (den_lcd)                          lo_cnt_q <= '0;
      else if (lo_cnt_q != CntW'(VBL_CYC))  lo_cnt_q <= lo_cnt_q + CntW'(1);

      // Vertical blanking re-anchors the frame even if a line fall lands on it.
      if (vbl_hit) begin
        y_q         <= '0;
        line_base_q <= '0;
      end else if (den_fall) begin
        if (y_q == 11'(HEIGHT - 1)) begin
          y_q         <= '0;
          line_base_q <= '0;
        end else begin
          y_q         <= y_q + 11'd1;
          line_base_q <= line_base_q + ADDR_W'(WIDTH);
        end
      end

      frame_start_q <= vbl_hit;
      if (vbl_hit) scan_locked_q <= 1'b1;

      // den_q is DEN one cycle old, so this lands two cycles after the DEN sample.
      pix_data_q  <= mem_rdata;
      pix_valid_q <= den_q & scan_locked_q & (state_q != StSeek);

      unique case (state_q)
        StSeek:   if (vbl_hit) state_q <= StVblank;
        StActive: if (!den_lcd) state_q <= StHblank;
        StHblank: begin
          if (den_lcd)      state_q <= StActive;
          else if (vbl_hit) state_q <= StVblank;
        end
        StVblank: if (den_lcd) state_q <= StActive;
        default:  state_q <= StSeek;
      endcase
    end
  end

endmodule

// File: tb/tb_ltm_fb_scan_arbiter.sv
// Randomised bench for ltm_fb_scan_arbiter against a line/pixel-index reference model.
module tb_ltm_fb_scan_arbiter;
  import ltm_pkg::*;

  localparam int unsigned W   = 800;
  localparam int unsigned H   = 6;
  localparam int unsigned VBL = 1000;
  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 16;
  localparam int unsigned QD  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          den_lcd = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr, wr_ready;
  logic [DW-1:0] mem_wdata, pix_data;
  logic [DW-1:0] mem_rdata = '0;
  logic          pix_valid, frame_start, scan_locked;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ltm_fb_scan_arbiter #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(QD), .VBL_CYC(VBL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .den_lcd    (den_lcd),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .scan_locked(scan_locked)
  );

  // RAM stand-in: contents are a scrambled function of the address.
  function automatic pixel_t ram_f(input logic [AW-1:0] a);
    int unsigned v;
    v = 32'(a) * 32'd40503 + 32'd977;
    return pixel_t'(v >> 7);
  endfunction

  always @(posedge clk) if (mem_rd) mem_rdata <= ram_f(mem_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wq[$];
  int            m_px, m_line, m_low, fs_exp_cnt, fs_obs_cnt;
  bit            m_den_prev, m_lock, m_fs, m_pv, rst_drive;
  logic [DW-1:0] m_pd;
  logic [AW-1:0] m_prev_addr;

  task automatic model_reset();
    m_px = 0; m_line = 0; m_low = 0;
    m_den_prev = 0; m_lock = 0; m_fs = 0; m_pv = 0;
    m_pd = '0; m_prev_addr = '0;
    wq.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_wr_ready"}, wr_ready, 1);
    check_eq({pfx, "_mem_rd"}, mem_rd, 0);
    check_eq({pfx, "_mem_wr"}, mem_wr, 0);
    check_eq({pfx, "_mem_addr"}, mem_addr, 0);
    check_eq({pfx, "_mem_wdata"}, mem_wdata, 0);
    check_eq({pfx, "_pix_data"}, pix_data, 0);
    check_eq({pfx, "_pix_valid"}, pix_valid, 0);
    check_eq({pfx, "_frame_start"}, frame_start, 0);
    check_eq({pfx, "_scan_locked"}, scan_locked, 0);
  endtask

  // One clock: drive at the falling edge, check, then advance the model over the rising edge.
  task automatic tick(input bit den, input bit wv);
    bit            exp_rd, exp_wr, exp_ready, nxt_pv;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, nxt_pd;
    wr_t           w;
    @(negedge clk);
    reset    = rst_drive;
    den_lcd  = den;
    wr_valid = wv && rst_drive;
    wr_addr  = AW'($urandom);
    wr_data  = DW'($urandom);
    #1;
    if (!rst_drive) begin
      check_reset_outputs("rst");
      model_reset();
      return;
    end
    if (frame_start) fs_obs_cnt++;
    exp_ready = wq.size() < QD;
    exp_rd    = den;
    exp_wr    = !den && wq.size() > 0;
    exp_addr  = '0;
    exp_wdata = '0;
    if (den) exp_addr = AW'(m_line * W + m_px);
    else if (exp_wr) begin
      exp_addr  = wq[0].addr;
      exp_wdata = wq[0].data;
    end
    check_eq("wr_ready", wr_ready, exp_ready);
    check_eq("mem_rd", mem_rd, exp_rd);
    check_eq("mem_wr", mem_wr, exp_wr);
    if (exp_rd || exp_wr) check_eq("mem_addr", mem_addr, exp_addr);
    if (exp_wr) check_eq("mem_wdata", mem_wdata, exp_wdata);
    check_eq("frame_start", frame_start, m_fs);
    check_eq("scan_locked", scan_locked, m_lock);
    check_eq("pix_valid", pix_valid, m_pv);
    if (m_pv) check_eq("pix_data", pix_data, m_pd);

    nxt_pv = m_den_prev && m_lock;
    nxt_pd = ram_f(m_prev_addr);
    if (exp_wr) void'(wq.pop_front());
    if (wv && exp_ready) begin
      w.addr = wr_addr;
      w.data = wr_data;
      wq.push_back(w);
    end
    m_fs = 0;
    if (den) begin
      m_px  = (m_px + 1) % W;
      m_low = 0;
    end else begin
      m_px = 0;
      if (m_low < VBL) begin
        m_low++;
        if (m_low == VBL) begin
          m_fs = 1; m_lock = 1; m_line = 0; fs_exp_cnt++;
        end
      end
    end
    if (!den && m_den_prev && !m_fs) m_line = (m_line + 1) % H;
    if (den) m_prev_addr = exp_addr;
    m_den_prev = den;
    m_pv = nxt_pv;
    m_pd = nxt_pd;
  endtask

  task automatic run_line(input int len, input int gap, input int pct);
    repeat (len) tick(1'b1, $urandom_range(99) < pct);
    repeat (gap) tick(1'b0, $urandom_range(99) < pct);
  endtask

  initial begin
    fs_exp_cnt = 0;
    fs_obs_cnt = 0;
    rst_drive  = 1'b0;
    model_reset();
    repeat (3) tick(1'b0, 1'b0);
    rst_drive = 1'b1;

    // Lock from a long DEN-low run
    repeat (VBL + 5) tick(1'b0, 1'b0);
    check_eq("lock_pulses", fs_obs_cnt, fs_exp_cnt);

    // Fill the queue during a line, then drain on DEN fall
    repeat (6) tick(1'b1, 1'b1);
    repeat (W - 6) tick(1'b1, 1'b0);
    repeat (10) tick(1'b0, 1'b0);

    // Two queued, then push and pop together in HBLANK
    repeat (2) tick(1'b1, 1'b1);
    repeat (W - 2) tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    repeat (9) tick(1'b0, 1'b0);

    // One gap just short of vertical blanking, rest of frame, then VBLANK
    run_line(W, VBL - 1, 20);
    for (int l = 0; l < H - 3; l++) run_line(W, $urandom_range(30, 1), 30);
    run_line(W, VBL + 10, 30);

    for (int f = 0; f < 3; f++) begin
      automatic int nl;
      nl = ($urandom_range(3) == 0) ? H + 1 : H;
      for (int l = 0; l < nl; l++) begin
        automatic int len;
        automatic int gap;
        len = ($urandom_range(4) == 0) ? $urandom_range(W + 20, 1) : W;
        gap = (l == nl - 1) ? VBL + $urandom_range(40) : $urandom_range(30, 1);
        run_line(len, gap, 30);
      end
    end

    // Asynchronous reset mid-line with three writes queued
    repeat (3) tick(1'b1, 1'b1);
    repeat (100) tick(1'b1, 1'b0);
    @(negedge clk);
    #3;
    reset     = 1'b0;
    rst_drive = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    repeat (3) tick(1'b1, 1'b0);
    rst_drive = 1'b1;
    repeat (20) tick(1'b0, 1'b0);
    run_line(W, 5, 30);
    run_line(W, VBL + 3, 30);
    for (int l = 0; l < H; l++) run_line(W, (l == H - 1) ? VBL + 2 : 4, 30);
    run_line(W, 4, 0);

    check_eq("frame_pulses", fs_obs_cnt, fs_exp_cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ltm_fb_scan_arbiter.md
Name: ltm_fb_scan_arbiter

Overview:
Shares one single-port frame-buffer memory between the LTM panel scan-out and a drawing-engine writer. Derives pixel position from the panel DEN signal and issues one read per active pixel. Writes are buffered in a small queue and drained only while DEN is low. It sits between the LTM timing source, the frame-buffer RAM and the pixel blender.

Parameters:
WIDTH, 800, active pixels per line
HEIGHT, 480, active lines per frame
ADDR_W, 19, frame-buffer address width (WIDTH*HEIGHT must fit)
DATA_W, 16, pixel width
WQ_DEPTH, 4, write-queue entries (power of 2)
VBL_CYC, 1000, consecutive DEN-low cycles that declare vertical blanking

Ports:
clk  in  1  LCD pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-low
den_lcd  in  1  panel data enable, synchronous to clk
wr_valid  in  1  writer request
wr_ready  out  1  queue not full
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
mem_addr  out  ADDR_W  RAM address
mem_rd  out  1  RAM read strobe
mem_wr  out  1  RAM write strobe
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_rd
pix_data  out  DATA_W  scanned pixel
pix_valid  out  1  pix_data valid
frame_start  out  1  1-cycle pulse on entry to VBLANK
scan_locked  out  1  high after the first frame_start

Behaviour:
- Reset values: every output is 0, except wr_ready=1. Counters, line base, queue pointers and the DEN-low counter are 0. State is SEEK.
- Reset mid-operation drops all queued writes and returns the block to SEEK.
- Position tracking:
  - x increments on each cycle with den_lcd=1 and wraps WIDTH-1 -> 0. den_lcd=0 forces x=0.
  - On a den 1->0 edge, y increments and line_base += WIDTH. At y=HEIGHT-1, y wraps to 0 and line_base to 0.
  - No multiplier: read address = line_base + x.
- DEN-low counter: counts consecutive den_lcd=0 cycles and saturates at VBL_CYC. When it reaches VBL_CYC:
  - y=0 and line_base=0;
  - frame_start pulses once;
  - scan_locked is set and held until reset.
- States:
  - SEEK: pix_valid forced 0; exits to VBLANK on the first frame_start.
  - ACTIVE: den_lcd=1.
  - HBLANK: den_lcd=0 and the counter is below VBL_CYC.
  - VBLANK: the counter has reached VBL_CYC.
  - Transitions: ACTIVE<->HBLANK on DEN edges; HBLANK->VBLANK on counter saturation; VBLANK->ACTIVE on DEN rise.
- Memory mux (combinational on den_lcd, in every state including SEEK):
  - den_lcd=1: mem_rd=1, mem_addr=line_base+x, mem_wr=0.
  - den_lcd=0 and queue non-empty: mem_wr=1, mem_addr/mem_wdata from the queue head; the head pops this cycle.
  - Otherwise all strobes are 0.
  - Scan always wins. A write can never coincide with a read.
- Pixel latency: pix_data registers mem_rdata. pix_valid = den_lcd delayed 2 cycles AND scan_locked. A DEN sample at cycle t gives a pixel at t+2.
- Write queue:
  - WQ_DEPTH-entry FIFO; wr_ready = !full.
  - Push when wr_valid && wr_ready. Push and pop in the same cycle leave occupancy unchanged.
  - When full, wr_ready=0 in the same cycle occupancy reaches WQ_DEPTH. A held wr_valid is not lost.
  - Pop order is FIFO. Writes stall indefinitely through ACTIVE.
- Width rules: x and y are 11 bit. line_base is ADDR_W bit. The line_base+x sum is truncated to ADDR_W.

Decomposition:
- Shared package ltm_pkg holds:
  - LTM_WIDTH, LTM_HEIGHT, LTM_VBL_CYC constants;
  - the state enum {SEEK, ACTIVE, HBLANK, VBLANK};
  - the pixel_t typedef [DATA_W-1:0].
- Sub-module ltm_wr_queue: parameterised FIFO with push/pop, full/empty and head outputs.
- The scan counters and mux stay in the top.

Test Plan:
- Reset with den_lcd=0 for 1000 cycles -> frame_start pulses at cycle 1000 from release, scan_locked=1, no pix_valid before that.
- After lock, den high for 800 cycles -> mem_addr 0..799 contiguous, pix_valid high exactly 800 cycles starting 2 cycles after DEN rise. Second line starts at mem_addr 800.
- Push 4 writes during ACTIVE -> wr_ready=0 after the 4th, mem_wr stays 0 while DEN=1. On DEN fall, the 4 writes appear on consecutive cycles in push order.
- Simultaneous push and pop in HBLANK with 2 entries queued -> occupancy stays 2, wr_ready=1.
- 480 lines then VBLANK -> y and line_base wrap; next frame's first read at mem_addr 0.
- Assert reset mid-line with 3 queued writes -> all outputs 0 immediately, queue empty, state SEEK, no stale mem_wr after release.
